// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC and drives the instruction-memory
// handshake. At most one request is outstanding. The fetched word is held
// for decode under valid/ready. Execute redirects retarget the PC, and a
// response that was already in flight at that point is discarded.
//
// Ports:
//   clk              clock, all state updates on posedge
//   reset            synchronous active-low reset
//   redirect_valid   execute requests a PC change
//   redirect_addr    redirect target (low two bits ignored, flagged if set)
//   imem_req_valid   fetch request valid
//   imem_req_addr    fetch byte address (always equals pc)
//   imem_req_ready   memory accepts the request
//   imem_resp_valid  response word valid
//   imem_resp_data   instruction word
//   if_valid         instruction available to decode
//   if_instr         held instruction
//   if_pc            address of if_instr
//   if_ready         decode accepts the instruction
//   pc               current fetch PC
//   misaligned_fault one-cycle pulse after a misaligned redirect target
//   fetch_count      instructions delivered to decode (wraps)
module fetch_sequencer #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready,
  output logic [31:0] pc,
  output logic        misaligned_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;
  logic [31:0] target;

  assign target = {redirect_addr[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StReq;
      pc_q       <= {RESET_ADDR[31:2], 2'b00};
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'h0;
      if_pc_q    <= 32'h0;
      fault_q    <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    count_d    = count_q;
    fault_d    = redirect_valid && (redirect_addr[1:0] != 2'b00);

    unique case (state_q)
      StReq: begin
        if (imem_req_ready) begin
          state_d = StWait;
          // A redirect in the accept cycle makes the response just requested stale.
          kill_d  = redirect_valid;
        end
        if (redirect_valid) pc_d = target;
      end
      StWait: begin
        if (imem_resp_valid) begin
          state_d = StReq;
          kill_d  = 1'b0;
          // Drop the word if it was already stale or a redirect lands with it.
          if (!kill_q && !redirect_valid) begin
            if_instr_d = imem_resp_data;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            state_d    = StHold;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
        if (redirect_valid) pc_d = target;
      end
      StHold: begin
        // Redirect beats a simultaneous handshake; the held word is not counted.
        if (redirect_valid) begin
          pc_d       = target;
          if_valid_d = 1'b0;
          state_d    = StReq;
        end else if (if_ready) begin
          count_d    = count_q + 32'd1;
          pc_d       = pc_q + 32'd4;
          if_valid_d = 1'b0;
          state_d    = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  assign imem_req_valid   = reset && (state_q == StReq);
  assign imem_req_addr    = pc_q;
  assign pc               = pc_q;
  assign if_valid         = if_valid_q;
  assign if_instr         = if_instr_q;
  assign if_pc            = if_pc_q;
  assign misaligned_fault = fault_q;
  assign fetch_count      = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed stimulus, a small instruction memory with
// adjustable latency, and a transaction-level model (request in flight? stale?
// instruction held?) checked against the DUT on every cycle, plus literal
// expectations at the interesting points of each scenario.
module tb_fetch_sequencer;

  localparam logic [31:0] ResetAddr = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [31:0] pc;
  logic        misaligned_fault;
  logic [31:0] fetch_count;

  int          n_vec = 0;
  int          n_err = 0;
  bit          check_en = 1'b0;
  int unsigned mem_lat = 1;

  // Memory state
  bit          mem_pend = 1'b0;
  int unsigned mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  // Model state
  logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_ipc = 32'h0, m_count = 32'h0;
  bit          m_busy = 1'b0, m_stale = 1'b0, m_held = 1'b0, m_fault = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_ADDR(ResetAddr)) dut (
    .clk              (clk),
    .reset            (reset),
    .redirect_valid   (redirect_valid),
    .redirect_addr    (redirect_addr),
    .imem_req_valid   (imem_req_valid),
    .imem_req_addr    (imem_req_addr),
    .imem_req_ready   (imem_req_ready),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .if_valid         (if_valid),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .if_ready         (if_ready),
    .pc               (pc),
    .misaligned_fault (misaligned_fault),
    .fetch_count      (fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
  endtask

  // Memory: sample an accepted request, answer mem_lat cycles later.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      mem_pend = 1'b0;
    end else if (imem_req_valid && imem_req_ready) begin
      mem_pend = 1'b1;
      mem_cnt  = mem_lat;
      mem_addr = imem_req_addr;
    end
  end

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (mem_pend && mem_cnt != 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(mem_addr);
          mem_pend        = 1'b0;
        end
      end
    end
  end

  // Model: one request in flight at most; a redirect marks it stale; a
  // held word leaves on handshake (pc+4) or is discarded by a redirect.
  initial forever begin
    logic [31:0] tgt;
    @(posedge clk);
    tgt = {redirect_addr[31:2], 2'b00};
    if (!reset) begin
      m_pc = ResetAddr; m_busy = 0; m_stale = 0; m_held = 0;
      m_instr = 32'h0; m_ipc = 32'h0; m_count = 32'h0; m_fault = 0;
    end else begin
      m_fault = redirect_valid && (redirect_addr[1:0] != 2'b00);
      if (m_held) begin
        if (redirect_valid) begin
          m_pc = tgt; m_held = 0;
        end else if (if_ready) begin
          m_count = m_count + 1; m_pc = m_pc + 4; m_held = 0;
        end
      end else if (!m_busy) begin
        if (imem_req_ready) begin
          m_busy = 1; m_stale = redirect_valid;
        end
        if (redirect_valid) m_pc = tgt;
      end else begin
        if (imem_resp_valid) begin
          m_busy = 0;
          if (!m_stale && !redirect_valid) begin
            m_held = 1; m_instr = imem_resp_data; m_ipc = m_pc;
          end
          m_stale = 0;
        end else if (redirect_valid) begin
          m_stale = 1;
        end
        if (redirect_valid) m_pc = tgt;
      end
    end
  end

  // Compare process
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk1("imem_req_valid", imem_req_valid, reset && !m_busy && !m_held);
      chk("imem_req_addr", imem_req_addr, m_pc);
      chk("pc", pc, m_pc);
      chk1("if_valid", if_valid, m_held);
      chk("if_instr", if_instr, m_instr);
      chk("if_pc", if_pc, m_ipc);
      chk1("misaligned_fault", misaligned_fault, m_fault);
      chk("fetch_count", fetch_count, m_count);
    end
  end

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'h0;
    imem_req_ready = 1'b1; if_ready = 1'b1;
    step();
    check_en = 1'b1;
    step();
    reset = 1'b1;                                        // c0

    // Straight-line fetch of 0x0, 0x4, 0x8 with a 1-cycle memory
    peek();
    chk1("lit req_valid c0", imem_req_valid, 1'b1);
    chk("lit req_addr c0", imem_req_addr, 32'h0);
    repeat (8) step();                                   // c8: holding 0x8
    peek();
    chk1("lit if_valid 0x8", if_valid, 1'b1);
    chk("lit if_pc 0x8", if_pc, 32'h8);
    chk("lit if_instr 0x8", if_instr, 32'h1357_9BD7);
    step();                                              // c9
    peek();
    chk("lit count 3", fetch_count, 32'd3);
    chk("lit pc 0xC", pc, 32'hC);

    // Decode stalls five cycles in hold
    step(); if_ready = 1'b0;                             // c10
    step();                                              // c11
    repeat (4) step();                                   // c15
    peek();
    chk1("lit stall if_valid", if_valid, 1'b1);
    chk("lit stall if_pc", if_pc, 32'hC);
    chk("lit stall pc", pc, 32'hC);
    chk1("lit stall no req", imem_req_valid, 1'b0);
    step(); if_ready = 1'b1;                             // c16
    step();                                              // c17
    peek();
    chk("lit release pc", pc, 32'h10);
    chk("lit release count", fetch_count, 32'd4);

    // Reset asserted while holding with if_ready high
    step(); step(); reset = 1'b0;                        // c19
    step();                                              // c20
    peek();
    chk1("lit rst if_valid", if_valid, 1'b0);
    chk("lit rst pc", pc, ResetAddr);
    chk("lit rst count", fetch_count, 32'd0);
    chk1("lit rst req_valid", imem_req_valid, 1'b0);
    step();
    peek();
    chk1("lit rst req_valid 2", imem_req_valid, 1'b0);
    step(); reset = 1'b1;                                // c0'

    // Redirect to 0x100 in the cycle the request for 0x8 is accepted
    repeat (6) step();                                   // c6': REQ 0x8
    redirect_valid = 1'b1; redirect_addr = 32'h100;
    step(); redirect_valid = 1'b0;                       // c7'
    peek();
    chk("lit redir pc", pc, 32'h100);
    chk1("lit redir no req", imem_req_valid, 1'b0);
    step();                                              // c8'
    peek();
    chk1("lit redir req_valid", imem_req_valid, 1'b1);
    chk("lit redir req_addr", imem_req_addr, 32'h100);
    chk1("lit 0x8 dropped", if_valid, 1'b0);
    step(); step();                                      // c10'
    peek();
    chk1("lit 0x100 valid", if_valid, 1'b1);
    chk("lit 0x100 if_pc", if_pc, 32'h100);
    chk("lit 0x100 instr", if_instr, 32'h1357_9ADF);
    chk("lit count 2", fetch_count, 32'd2);

    // Misaligned redirect to 0x203 while waiting on a slow response
    step(); mem_lat = 3;                                 // c11': REQ 0x104
    step();                                              // c12': WAIT
    redirect_valid = 1'b1; redirect_addr = 32'h203;
    step(); redirect_valid = 1'b0;                       // c13'
    peek();
    chk1("lit fault pulse", misaligned_fault, 1'b1);
    chk("lit fault pc", pc, 32'h200);
    step(); mem_lat = 1;                                 // c14'
    peek();
    chk1("lit fault once", misaligned_fault, 1'b0);
    step();                                              // c15'
    peek();
    chk1("lit stale dropped", if_valid, 1'b0);
    chk("lit req 0x200", imem_req_addr, 32'h200);
    step(); step();                                      // c17'
    peek();
    chk("lit if_pc 0x200", if_pc, 32'h200);

    // Redirect while request not accepted, then wrap past 0xFFFF_FFFC
    step();                                              // c18': REQ 0x204
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC;
    step(); redirect_valid = 1'b0; imem_req_ready = 1'b1;  // c19'
    peek();
    chk("lit top req_addr", imem_req_addr, 32'hFFFF_FFFC);
    step(); step();                                      // c21'
    peek();
    chk("lit top if_pc", if_pc, 32'hFFFF_FFFC);
    step();                                              // c22'
    peek();
    chk("lit wrap req_addr", imem_req_addr, 32'h0);
    chk("lit wrap count", fetch_count, 32'd5);

    // Redirect beats if_ready in hold
    step(); step();                                      // c24': HOLD
    redirect_valid = 1'b1; redirect_addr = 32'h40;
    step(); redirect_valid = 1'b0;                       // c25'
    peek();
    chk("lit no count", fetch_count, 32'd5);
    chk1("lit hold dropped", if_valid, 1'b0);
    chk("lit pc 0x40", pc, 32'h40);

    // Back-to-back redirects during a slow response: last one wins
    mem_lat = 3;
    step();                                              // c26': WAIT
    redirect_valid = 1'b1; redirect_addr = 32'h80;
    step(); redirect_addr = 32'h90; mem_lat = 1;         // c27'
    step(); redirect_valid = 1'b0;                       // c28'
    step();                                              // c29'
    peek();
    chk("lit b2b req_addr", imem_req_addr, 32'h90);
    chk1("lit b2b dropped", if_valid, 1'b0);
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequences the program counter and the instruction-memory fetch handshake for the x32 core. Owns the fetch PC, issues one outstanding request at a time, and presents fetched instructions to decode with valid/ready. Takes taken-branch/jump/jal/jalr redirects from execute and discards any stale in-flight response. Sits between the branch unit, instruction memory and decode.

Parameters:
RESET_ADDR, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-low reset (0 = reset asserted, sampled on posedge clk).
redirect_valid  input  1  execute requests PC change (taken branch, jump, jal, jalr).
redirect_addr  input  32  redirect target.
imem_req_valid  output  1  fetch request valid.
imem_req_addr  output  32  fetch byte address; always equals pc.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_resp_valid  input  1  response data valid; at most one per accepted request, at least 1 cycle after acceptance.
imem_resp_data  input  32  instruction word.
if_valid  output  1  instruction available to decode.
if_instr  output  32  held instruction.
if_pc  output  32  address of if_instr.
if_ready  input  1  decode accepts the instruction.
pc  output  32  current fetch PC.
misaligned_fault  output  1  one-cycle pulse: redirect target with [1:0] != 0.
fetch_count  output  32  instructions delivered to decode (if_valid & if_ready), wraps.

Behaviour:
- Reset (reset==0 at posedge): pc=RESET_ADDR, state=S_REQ, kill=0, if_valid=0, if_instr=0, if_pc=0, misaligned_fault=0, fetch_count=0. imem_req_valid is 0 while reset is low.
- States: S_REQ (request driven), S_WAIT (request accepted, response pending), S_HOLD (instruction held for decode).
- S_REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready -> S_WAIT.
- S_WAIT: imem_req_valid=0. On imem_resp_valid: if kill, drop the data, clear kill -> S_REQ; else capture if_instr=resp_data, if_pc=pc, set if_valid -> S_HOLD (if_valid high the cycle after the response).
- S_HOLD: if_valid=1, if_instr/if_pc stable. On if_ready: fetch_count+=1, pc<=pc+4, if_valid<=0 -> S_REQ.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- Redirect (highest priority after reset). Target = {redirect_addr[31:2],2'b00}. misaligned_fault pulses on the next cycle if redirect_addr[1:0]!=0.
  - S_REQ, not accepted: pc<=target, stay S_REQ. The only permitted address change under valid without ready.
  - S_REQ, accepted same cycle: pc<=target, kill<=1 -> S_WAIT.
  - S_WAIT: pc<=target, kill<=1. If the response also arrives that cycle, drop it, kill stays 0 -> S_REQ.
  - S_HOLD: pc<=target, if_valid<=0 -> S_REQ. The redirect wins over a simultaneous if_ready; the held instruction is not counted.
  - Back-to-back redirects: the last one wins. kill stays set until exactly one response is dropped.
- Best-case latency with a 1-cycle memory and if_ready held high is 3 cycles per instruction: REQ accepted at t, response at t+1, if_valid at t+2 with handshake at t+2, next REQ at t+3.
- Reset asserted in any state overrides all inputs. A response arriving after reset for a pre-reset request is not possible by memory contract; the sequencer need not filter it.

Test Plan:
- Reset release, RESET_ADDR=0, 1-cycle memory, if_ready=1 -> requests at 0x0, 0x4, 0x8 every 3 cycles; if_pc matches; fetch_count=3 after third handshake.
- if_ready low for 5 cycles in S_HOLD -> if_valid, if_instr and if_pc stable, no new request, pc unchanged; on release, pc advances by 4.
- Redirect to 0x100 in the same cycle the request for 0x8 is accepted -> response for 0x8 dropped (no if_valid), next request to 0x100, if_pc=0x100.
- Redirect to 0x203 during S_WAIT -> misaligned_fault pulses once, next request address 0x200.
- Redirect to 0xFFFF_FFFC, fetch and accept -> next request address 0x0000_0000.
- Reset driven low in S_HOLD with if_ready=1 -> next cycle if_valid=0, pc=RESET_ADDR, fetch_count=0, imem_req_valid=0 until reset goes high.
